mem_stage: RTL and testbench

Memory stage of the SEQ Y86-64 processor. It sits directly downstream of the execute stage and consumes `icode`, `valE` and `valA` from execute, plus `valP` from fetch. It performs the instruction's data-memory read or write against an internal byte-addressed data memory, returning `valM` and a memory-error flag to write-back and PC update. Accesses are byte-serial, so the stage is multi-cycle and uses a valid/ready handshake on input and a done pulse on output.

---
 rtl/y86_pkg.sv | 44 ++++
 rtl/dmem_bytes.sv | 23 ++
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, memory-stage state encoding,
// status codes and small decode helpers used by the memory stage.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } mem_state_t;

  // Instructions that store a quadword to data memory.
  function automatic logic is_mem_write(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
  endfunction

  // Instructions that load a quadword from data memory.
  function automatic logic is_mem_read(input logic [3:0] ic);
    return (ic == IMRMOVQ) || (ic == IRET) || (ic == IPOPQ);
  endfunction

  // Stack pops (ret/popq) address memory with the old stack pointer in valA.
  function automatic logic addr_from_vala(input logic [3:0] ic);
    return (ic == IRET) || (ic == IPOPQ);
  endfunction

endpackage

// File: rtl/dmem_bytes.sv
// Byte-wide single-port data memory: synchronous write, asynchronous read.
// Contents are never reset.
module dmem_bytes #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store one byte on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// SEQ Y86-64 memory stage: byte-serial quadword load/store against an
// internal byte-addressed memory, with valid/ready intake and a done pulse.
module mem_stage
  import y86_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        done,
  output logic [63:0] valM,
  output logic        mem_err
);

  localparam int          AW       = $clog2(DEPTH);
  // Highest legal start address of an 8-byte access, compared unsigned so
  // addresses near 2^64 cannot wrap into range.
  localparam logic [63:0] ADDR_MAX = 64'(DEPTH - 8);

  mem_state_t    state, state_nxt;
  logic [2:0]    cnt;
  logic          op_wr;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;

  logic          accept;
  logic          req_wr, req_rd, req_oor, req_go;
  logic [63:0]   req_addr, req_data;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata, ram_rdata;

  // Decode the incoming request: direction, address source, data source, range.
  always_comb begin
    req_wr   = is_mem_write(icode);
    req_rd   = is_mem_read(icode);
    req_addr = addr_from_vala(icode) ? valA : valE;
    req_data = (icode == ICALL) ? valP : valA;
    req_oor  = (req_rd || req_wr) && (req_addr > ADDR_MAX);
    req_go   = (req_rd || req_wr) && !req_oor;
  end

  assign accept = in_valid && in_ready;

  // State register; reset aborts any access in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: legal accesses walk 8 bytes, everything else goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = req_go ? S_ACCESS : S_DONE;
      S_ACCESS: if (cnt == 3'd7) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready = (state == S_IDLE);
    done     = (state == S_DONE);
  end

  // Control registers: byte counter, direction and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 3'd0;
      op_wr   <= 1'b0;
      mem_err <= 1'b0;
    end else if (accept) begin
      cnt     <= 3'd0;
      op_wr   <= req_wr;
      mem_err <= req_oor;
    end else if (state == S_ACCESS) begin
      cnt     <= cnt + 3'd1;
    end
  end

  // Request operands latched at accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr[AW-1:0];
      wdata_q <= req_data;
    end
  end

  // Load result assembled little-endian one byte per ACCESS cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          valM <= 64'd0;
    else if (accept)                     valM <= 64'd0;
    else if (state == S_ACCESS && !op_wr) valM[8*cnt +: 8] <= ram_rdata;
  end

  assign ram_we    = (state == S_ACCESS) && op_wr;
  assign ram_addr  = addr_q + AW'(cnt);
  assign ram_wdata = wdata_q[8*cnt +: 8];

  dmem_bytes #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage with a byte-array reference model.
module tb_mem_stage;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        done;
  logic [63:0] valM;
  logic        mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mm [DEPTH];

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .icode    (icode),
    .valE     (valE),
    .valA     (valA),
    .valP     (valP),
    .done     (done),
    .valM     (valM),
    .mem_err  (mem_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full transaction from IDLE; expectations come from the instruction
  // semantics applied to the byte-array model. Enters and leaves at a negedge.
  task automatic do_op(input logic [3:0] ic, input logic [63:0] e,
                       input logic [63:0] a, input logic [63:0] p);
    logic        wr, rd, oor;
    logic [63:0] ad, dat, exp_m;
    int          exp_lat, k;
    wr  = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
    rd  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    ad  = (ic == 4'h9 || ic == 4'hB) ? a : e;
    dat = (ic == 4'h8) ? p : a;
    oor = (wr || rd) && (ad > 64'(DEPTH - 8));
    exp_m = 64'd0;
    if (rd && !oor)
      for (int b = 0; b < 8; b++) exp_m[8*b +: 8] = mm[int'(ad[31:0]) + b];
    exp_lat = ((wr || rd) && !oor) ? 9 : 1;

    chk("ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    icode = ic; valE = e; valA = a; valP = p;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    icode = 4'($urandom); valE = rnd64(); valA = rnd64(); valP = rnd64();
    if (wr && !oor)
      for (int b = 0; b < 8; b++) mm[int'(ad[31:0]) + b] = dat[8*b +: 8];

    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 30);
    chk("latency", 64'(k), 64'(exp_lat));
    chk("valM", valM, exp_m);
    chk("mem_err", {63'd0, mem_err}, {63'd0, oor});
    chk("ready_busy", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("valM_hold", valM, exp_m);
  endtask

  initial begin
    int accepts, dones, last;
    logic [63:0] ad;
    logic [3:0]  ic;
    logic [63:0] e, a, p;

    rst_n = 1'b0; in_valid = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_err", {63'd0, mem_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Give every byte a known value.
    for (int ai = 0; ai <= DEPTH - 8; ai += 8) do_op(4'h4, 64'(ai), rnd64(), rnd64());

    // rmmovq then mrmovq round trip.
    do_op(4'h4, 64'h10, 64'h1122334455667788, rnd64());
    do_op(4'h5, 64'h10, rnd64(), rnd64());
    chk("rm_mr_value", valM, 64'h1122334455667788);

    // pushq / popq: popq address comes from valA.
    do_op(4'hA, 64'h1F8, 64'hAB, rnd64());
    do_op(4'hB, 64'h200, 64'h1F8, rnd64());
    chk("push_pop_value", valM, 64'hAB);

    // Out-of-range accesses, including one near 2^64 that must not wrap.
    do_op(4'h5, 64'(DEPTH - 7), rnd64(), rnd64());
    do_op(4'h4, 64'hFFFF_FFFF_FFFF_FFFC, rnd64(), rnd64());
    do_op(4'h5, 64'(DEPTH - 8), rnd64(), rnd64());
    do_op(4'h5, 64'h0, rnd64(), rnd64());

    // No-access instruction.
    do_op(4'h6, 64'h20, rnd64(), rnd64());
    do_op(4'h5, 64'h20, rnd64(), rnd64());

    // in_valid held high across back-to-back reads.
    in_valid = 1'b1; icode = 4'h5; valE = 64'h40; valA = rnd64(); valP = rnd64();
    accepts = 0; dones = 0; last = -1;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      if (in_ready) begin
        accepts++;
        if (last >= 0) chk("b2b_gap", 64'(i - last), 64'd10);
        last = i;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 64'(accepts), 64'd4);
    chk("b2b_dones", 64'(dones), 64'd4);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);

    // call aborted by reset after four bytes.
    in_valid = 1'b1; icode = 4'h8; valE = 64'h100; valA = rnd64(); valP = 64'h0102030405060708;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_nodone", {63'd0, done}, 64'd0);
    chk("abort_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done_after", 64'(dones), 64'd0);
    chk("abort_idle", {63'd0, in_ready}, 64'd1);
    mm[256] = 8'h08; mm[257] = 8'h07; mm[258] = 8'h06; mm[259] = 8'h05;
    do_op(4'h5, 64'h100, rnd64(), rnd64());
    chk("abort_low_bytes", {32'd0, valM[31:0]}, 64'h05060708);

    // Random mix checked against the model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        8:       ad = 64'($urandom_range(DEPTH - 7, DEPTH + 20));
        9:       ad = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: ad = 64'($urandom_range(0, DEPTH - 8));
      endcase
      ic = 4'($urandom);
      e = rnd64(); a = rnd64(); p = rnd64();
      if (ic == 4'h9 || ic == 4'hB) a = ad;
      else                          e = ad;
      do_op(ic, e, a, p);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
